// File: rtl/mvu_pkg.sv
// Shared constants and types for the MVU jump address generator.
// Optional feature macro: MVU_AGU_LOOPFLAGS_EN (per-level loop-end flags).
package mvu_pkg;

  localparam int NJUMPS  = 5;        // number of loop levels
  localparam int BADDR   = 15;       // address width
  localparam int BJUMP   = 15;       // signed stride width
  localparam int BLENGTH = 15;       // per-level iteration-length width
  localparam int BCNTDWN = BLENGTH;  // width of each per-level countdown counter

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } agu_state_t;

endpackage

// File: rtl/mvu_agu_lvlsel.sv
// Level selector: picks the lowest loop level whose countdown is non-zero
// and flags every level below it for reload with its iteration length.
module mvu_agu_lvlsel #(
  parameter int NJUMPS = mvu_pkg::NJUMPS
) (
  input  logic [NJUMPS-1:0] cnt_zero,
  output logic [NJUMPS-1:0] sel,
  output logic [NJUMPS-1:0] reload
);

  import mvu_pkg::*;

  // Priority encode from level 0 upward; levels passed over are exhausted.
  always_comb begin
    logic found;
    // NOTE: every output gets a default before the loop so no path leaves
    // a bit unassigned, which would otherwise infer a latch.
    sel    = '0;
    reload = '0;
    found  = 1'b0;
    for (int i = 0; i < NJUMPS; i++) begin
      if (!found) begin
        if (cnt_zero[i]) begin
          reload[i] = 1'b1;
        end else begin
          sel[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mvu_jump_agu.sv
// Nested-loop address generator: NJUMPS levels, each with its own signed
// stride and iteration length, one address per accepted valid/ready beat.
// Optional feature macro: MVU_AGU_LOOPFLAGS_EN adds loop_end_o.
module mvu_jump_agu #(
  parameter int NJUMPS  = mvu_pkg::NJUMPS,
  parameter int BADDR   = mvu_pkg::BADDR,
  parameter int BJUMP   = mvu_pkg::BJUMP,
  parameter int BLENGTH = mvu_pkg::BLENGTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      clr,
  input  logic [BADDR-1:0]          base_addr,
  input  logic [NJUMPS*BJUMP-1:0]   jump,
  input  logic [NJUMPS*BLENGTH-1:0] length,
  output logic [BADDR-1:0]          addr_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic                      last_o,
  output logic                      busy_o,
  output logic                      done_o
`ifdef MVU_AGU_LOOPFLAGS_EN
  ,
  output logic [NJUMPS-1:0]         loop_end_o
`endif
);

  import mvu_pkg::*;

  agu_state_t         state_q;
  logic [BADDR-1:0]   addr_q;
  logic               valid_q;
  logic               done_q;
  logic [BLENGTH-1:0] cnt_q  [NJUMPS];
  logic [BLENGTH-1:0] len_q  [NJUMPS];
  logic [BJUMP-1:0]   jump_q [NJUMPS];

  logic [NJUMPS-1:0]  cnt_zero;
  logic [NJUMPS-1:0]  sel;
  logic [NJUMPS-1:0]  reload;
  logic [BADDR-1:0]   step;
  logic               all_zero;
  logic               accept;

  // Flag exhausted levels from the registered counters.
  always_comb begin
    cnt_zero = '0;
    for (int i = 0; i < NJUMPS; i++) begin
      cnt_zero[i] = (cnt_q[i] == '0);
    end
  end

  mvu_agu_lvlsel #(
    .NJUMPS (NJUMPS)
  ) u_lvlsel (
    .cnt_zero (cnt_zero),
    .sel      (sel),
    .reload   (reload)
  );

  // Sign-extended stride of the selected level; wraps modulo 2^BADDR.
  always_comb begin
    step = '0;
    for (int i = 0; i < NJUMPS; i++) begin
      if (sel[i]) begin
        step = step | BADDR'($signed(jump_q[i]));
      end
    end
  end

  assign all_zero = &cnt_zero;
  assign accept   = valid_q & ready_i;

  // Sequencer: launch, step through the loop nest, abort on clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      // NOTE: the shadow registers are reset along with the counters; they
      // are a handful of flops, and it keeps unknowns out of the datapath.
      for (int i = 0; i < NJUMPS; i++) begin
        cnt_q[i]  <= '0;
        len_q[i]  <= '0;
        jump_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // pre-edge state regardless of statement order.
      done_q <= 1'b0;
      if (clr) begin
        state_q <= IDLE;
        valid_q <= 1'b0;
        for (int i = 0; i < NJUMPS; i++) begin
          cnt_q[i] <= '0;
        end
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              state_q <= RUN;
              valid_q <= 1'b1;
              addr_q  <= base_addr;
              for (int i = 0; i < NJUMPS; i++) begin
                len_q[i]  <= length[i*BLENGTH +: BLENGTH];
                jump_q[i] <= jump[i*BJUMP +: BJUMP];
                cnt_q[i]  <= length[i*BLENGTH +: BLENGTH];
              end
            end
          end
          RUN: begin
            if (accept) begin
              if (all_zero) begin
                state_q <= IDLE;
                valid_q <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                addr_q <= addr_q + step;
                for (int i = 0; i < NJUMPS; i++) begin
                  if (reload[i]) begin
                    cnt_q[i] <= len_q[i];
                  end else if (sel[i]) begin
                    cnt_q[i] <= cnt_q[i] - BLENGTH'(1);
                  end
                end
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign addr_o  = addr_q;
  assign valid_o = valid_q;
  assign last_o  = valid_q & all_zero;
  assign busy_o  = (state_q == RUN);
  assign done_o  = done_q;

`ifdef MVU_AGU_LOOPFLAGS_EN
  // Level i completes on this beat when levels 0..i are all exhausted.
  always_comb begin
    logic acc;
    acc        = 1'b1;
    loop_end_o = '0;
    for (int i = 0; i < NJUMPS; i++) begin
      acc           = acc & cnt_zero[i];
      loop_end_o[i] = valid_q & acc;
    end
  end
`endif

endmodule

// File: tb/tb_mvu_jump_agu.sv
// Scoreboard bench for mvu_jump_agu: launches push the expected beat list,
// a negedge monitor pops and compares on every accepted beat.
module tb_mvu_jump_agu;

  localparam int NJ = mvu_pkg::NJUMPS;
  localparam int BA = mvu_pkg::BADDR;
  localparam int BJ = mvu_pkg::BJUMP;
  localparam int BL = mvu_pkg::BLENGTH;
  localparam longint AMASK = (64'd1 << BA) - 1;

  typedef struct {
    longint addr;
    bit     last;
    longint le;
  } beat_t;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              clr;
  logic [BA-1:0]     base_addr;
  logic [NJ*BJ-1:0]  jump;
  logic [NJ*BL-1:0]  length;
  logic [BA-1:0]     addr_o;
  logic              valid_o;
  logic              ready_i;
  logic              last_o;
  logic              busy_o;
  logic              done_o;
`ifdef MVU_AGU_LOOPFLAGS_EN
  logic [NJ-1:0]     loop_end_o;
`endif

  mvu_jump_agu dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .clr        (clr),
    .base_addr  (base_addr),
    .jump       (jump),
    .length     (length),
    .addr_o     (addr_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .last_o     (last_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
`ifdef MVU_AGU_LOOPFLAGS_EN
    ,
    .loop_end_o (loop_end_o)
`endif
  );

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    cj[NJ];
  int    cl[NJ];
  int    rmode = 0;
  int    pidx  = 0;
  bit    junk  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: beat n of the nest has level i stepped floor(n/N_i)-floor(n/N_{i+1})
  // times, where N_i is the product of (length+1) of all levels below i.
  task automatic push_run(longint base);
    longint n_at[NJ+1];
    longint a;
    beat_t  b;
    n_at[0] = 1;
    for (int i = 0; i < NJ; i++) n_at[i+1] = n_at[i] * (cl[i] + 1);
    for (longint n = 0; n < n_at[NJ]; n++) begin
      a    = base;
      b.le = 0;
      for (int i = 0; i < NJ; i++) begin
        a += longint'(cj[i]) * (n / n_at[i] - n / n_at[i+1]);
        if ((n + 1) % n_at[i+1] == 0) b.le |= (64'd1 << i);
      end
      b.addr = a & AMASK;
      b.last = (n == n_at[NJ] - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic drive_cfg(int base);
    base_addr = BA'(base);
    for (int i = 0; i < NJ; i++) begin
      jump[i*BJ +: BJ]   = cj[i][BJ-1:0];
      length[i*BL +: BL] = cl[i][BL-1:0];
    end
  endtask

  task automatic clear_cfg();
    for (int i = 0; i < NJ; i++) begin
      cj[i] = 0;
      cl[i] = 0;
    end
  endtask

  task automatic set_two_level();
    clear_cfg();
    cj[0] = 1;  cl[0] = 3;
    cj[1] = 16; cl[1] = 2;
  endtask

  // Called one step after a rising edge; returns one step after the next.
  task automatic launch(int base);
    drive_cfg(base);
    push_run(longint'(base));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy_o, 1);
    check("valid_after_start", valid_o, 1);
  endtask

  task automatic run_to_end(int budget);
    int c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      if (junk) begin
        base_addr = BA'($urandom);
        jump      = {$urandom, $urandom, $urandom};
        length    = {$urandom, $urandom, $urandom};
        start     = (exp_q.size() >= 2) && ($urandom_range(0, 3) == 0);
      end
      @(posedge clk); #1;
      c++;
    end
    start = 1'b0;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL run_timeout: %0d beats outstanding, required 0", exp_q.size());
      exp_q.delete();
    end else begin
      check("busy_at_end", busy_o, 0);
    end
  endtask

  // Ready driver: 0 = always ready, 1 = repeating 1,0,0,1, 2 = random.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rmode)
        1: begin
          ready_i = (pidx % 4 == 0) || (pidx % 4 == 3);
          pidx++;
        end
        2:       ready_i = $urandom_range(0, 1) == 1;
        default: ready_i = 1'b1;
      endcase
    end
  end

  // Monitor: pops one expected beat per accepted handshake.
  initial begin
    bit            pending_done = 0;
    bit            prev_stall   = 0;
    logic [BA-1:0] prev_addr    = '0;
    logic          prev_last    = 1'b0;
    bit            acc;
    beat_t         b;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pending_done = 0;
        prev_stall   = 0;
      end else begin
        check("done_o", done_o, pending_done);
        if (prev_stall) begin
          check("stall_addr", addr_o, prev_addr);
          check("stall_valid", valid_o, 1);
          check("stall_last", last_o, prev_last);
        end
        if (!valid_o) check("idle_last", last_o, 0);
        acc          = valid_o && ready_i && !clr;
        pending_done = 0;
        if (acc) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_beat: addr %0d presented, required no beat", addr_o);
          end else begin
            b = exp_q.pop_front();
            check("addr", addr_o, b.addr);
            check("last", last_o, b.last);
`ifdef MVU_AGU_LOOPFLAGS_EN
            check("loop_end", loop_end_o, b.le);
`endif
            pending_done = b.last;
          end
        end
        prev_stall = valid_o && !ready_i && !clr;
        prev_addr  = addr_o;
        prev_last  = last_o;
      end
    end
  end

  task automatic check_all_zero(string tag);
    check({tag, "_addr"}, addr_o, 0);
    check({tag, "_valid"}, valid_o, 0);
    check({tag, "_last"}, last_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, done_o, 0);
`ifdef MVU_AGU_LOOPFLAGS_EN
    check({tag, "_loop_end"}, loop_end_o, 0);
`endif
  endtask

  initial begin
    int c;
    rst_n = 1'b0;
    start = 1'b0;
    clr   = 1'b0;
    clear_cfg();
    drive_cfg(0);
    #3;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single level, unit stride: 10..13.
    clear_cfg();
    cj[0] = 1; cl[0] = 3;
    launch(10);
    run_to_end(50);

    // Two levels: 0,1,2,3,19,...,41.
    set_two_level();
    launch(0);
    run_to_end(50);

    // Negative stride wrapping below zero: 5,3,1,32767.
    clear_cfg();
    cj[0] = -2; cl[0] = 3;
    launch(5);
    run_to_end(50);

    // Two levels under a 1,0,0,1 ready pattern.
    rmode = 1;
    pidx  = 0;
    set_two_level();
    launch(0);
    run_to_end(100);
    rmode = 0;
    @(posedge clk); #1;

    // clr while the 4th beat is presented, then restart from base.
    set_two_level();
    launch(0);
    c = 0;
    while (exp_q.size() > 9 && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    check("clr_reached_beat4", exp_q.size(), 9);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    exp_q.delete();
    check("clr_valid", valid_o, 0);
    check("clr_busy", busy_o, 0);
    @(posedge clk); #1;
    launch(0);
    run_to_end(50);

    // start and clr together while idle: clr wins.
    @(posedge clk); #1;
    start = 1'b1;
    clr   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    clr   = 1'b0;
    check("start_clr_valid", valid_o, 0);
    check("start_clr_busy", busy_o, 0);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a run.
    set_two_level();
    launch(0);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Randomised nests, random ready, input noise and ignored starts mid-run,
    // with each launch landing in the previous run's done cycle.
    rmode = 2;
    junk  = 1;
    for (int r = 0; r < 25; r++) begin
      int nl;
      nl = $urandom_range(1, NJ);
      clear_cfg();
      for (int i = 0; i < NJ; i++) begin
        cj[i] = $urandom_range(0, 32767) - 16384;
        if (i < nl) cl[i] = (i < 2) ? $urandom_range(0, 3) : $urandom_range(0, 2);
      end
      launch($urandom_range(0, 32767));
      run_to_end(4000);
    end
    junk  = 0;
    rmode = 0;
    repeat (3) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mvu_jump_agu.md
# mvu_jump_agu

Parametrised nested-loop address generator for MVU weight, data and high-precision banks. Replaces fixed-depth, single-stride address counters with NJUMPS configurable loop levels. Each level has its own signed stride and iteration length. It issues one address per accepted beat under a valid/ready handshake and sits between the MVU controller (command side) and a memory read port (address side).

## Interface
- NJUMPS, 5, number of loop levels (≥1)
- BADDR, 15, address width (BDBANKA for data, BWBANKA for weights, BDHPBANKA for HP banks)
- BJUMP, 15, signed stride width
- BLENGTH, 15, per-level iteration-length width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  launch pulse; sampled only when idle
- clr  in  1  synchronous abort, returns to IDLE
- base_addr  in  BADDR  first address of the sequence
- jump  in  NJUMPS×BJUMP  signed stride per level, jump[0] innermost
- length  in  NJUMPS×BLENGTH  per-level iteration count minus one
- addr_o  out  BADDR  current address
- valid_o  out  1  addr_o is valid
- ready_i  in  1  consumer accepts addr_o this cycle
- last_o  out  1  current beat is the final one of the sequence
- busy_o  out  1  sequence in progress
- done_o  out  1  one-cycle pulse after the final beat is accepted

## Operation
- States: IDLE, RUN.
- IDLE: start=1 → RUN.
  - Latch jump/length into shadow registers; later input changes have no effect until the next start.
  - addr ← base_addr; cnt[i] ← length[i] for all i.
- RUN: valid_o=1. A beat is accepted when valid_o & ready_i.
- On accept, find k = lowest level with cnt[k]≠0:
  - cnt[k] decrements; cnt[j] ← length[j] for all j<k.
  - addr ← addr + sign-extended jump[k], modulo 2^BADDR (silent wrap).
- last_o = valid_o & all cnt[i]==0.
- Accept with last_o=1 → IDLE, done_o=1 next cycle.
- Total beats = Π(length[i]+1). length[i]=0 means that level runs once.
- clr has priority over start and accept: → IDLE, counters cleared, no done_o.
- start while RUN is ignored.
- start and clr in the same idle cycle: clr wins and the generator stays IDLE.
- ready_i=0 holds addr_o, valid_o, last_o and all counters stable.

## Timing
- Reset values: addr_o=0, valid_o=0, last_o=0, busy_o=0, done_o=0, state IDLE.
- start at cycle t → valid_o=1 with addr_o=base_addr at t+1.
- Throughput: one address per cycle while ready_i=1.
- addr_o and valid_o are registered. last_o is registered-derived (no ready_i→output combinational path).
- done_o asserts the cycle after the final accept. busy_o falls in that same cycle. A new start is accepted in that cycle.
- rst_n asserted mid-sequence: all outputs return to reset values immediately. No done_o.

## Configuration
- MVU_AGU_LOOPFLAGS_EN defined:
  - Adds output loop_end_o [NJUMPS-1:0].
  - Bit i is high on the beat where cnt[0..i] are all zero, i.e. level i completes on this beat.
  - The scaler/pool stages use it for accumulator flush.
- Undefined: the port is absent and no extra logic is generated.

## Structure
- Shared in mvu_pkg: NJUMPS, BJUMP, BLENGTH, BCNTDWN, and the typedef agu_state_t {IDLE, RUN}.
- One sub-module, mvu_agu_lvlsel:
  - Combinational priority encoder from cnt-zero flags to the selected level k.
  - Also produces the reload mask for levels below k.

## Test plan
- NJUMPS=1, base=10, jump[0]=1, length[0]=3, ready=1 → addresses 10,11,12,13; last_o on 13; done_o one cycle later.
- 2 levels, base=0, jump={16,1}, length={2,3} → 0,1,2,3,19,20,21,22,38,39,40,41 (12 beats).
- Negative stride: base=5, jump[0]=-2, length[0]=3, BADDR=15 → 5,3,1,32767 (wrap).
- ready_i toggled 1,0,0,1 during the 2-level case → sequence identical; addr held during stall cycles.
- clr asserted on the 4th beat of a 12-beat run → valid_o=0 next cycle, no done_o; a fresh start then restarts from base.
- rst_n pulsed low mid-run → all outputs 0 asynchronously; with MVU_AGU_LOOPFLAGS_EN, loop_end_o=0b01 on beats 3,22 and 0b11 on beat 41 of the 2-level case.
